// File: rtl/truss_heartbeat_watchdog.sv
// Hardware end of the testbench watchdog handshake: armed and kicked by the bench,
// it raises WARN near expiry and a sticky EXPIRED/timeout until acknowledged.
module truss_heartbeat_watchdog #(
    parameter int CNT_W       = 16,
    parameter int WARN_CYCLES = 8,
    parameter int EV_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             kick,
    input  logic             disarm,
    input  logic             ack,
    input  logic [CNT_W-1:0] timeout_value,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] remaining,
    output logic             warning,
    output logic             timeout,
    output logic             timeout_pulse,
    output logic [EV_W-1:0]  expire_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_WARN    = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WARN_TH = CNT_W'(WARN_CYCLES);

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_load;
    logic             r_pulse;
    logic [EV_W-1:0]  r_expire_count;

    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_remaining;
    logic [CNT_W-1:0] w_nxt_load;
    logic [CNT_W-1:0] w_dec;
    logic             w_enter_expired;

    // 0 is terminal: the decrement never wraps even if reached unexpectedly.
    assign w_dec = (r_remaining == '0) ? '0 : r_remaining - CNT_W'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_nxt_state     = r_state;
        w_nxt_remaining = r_remaining;
        w_nxt_load      = r_load;
        if (disarm) begin
            w_nxt_state     = S_IDLE;
            w_nxt_remaining = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        w_nxt_load = timeout_value;
                        if (timeout_value == '0) begin
                            w_nxt_state     = S_EXPIRED;
                            w_nxt_remaining = '0;
                        end else begin
                            w_nxt_state     = S_ARMED;
                            w_nxt_remaining = timeout_value;
                        end
                    end
                end
                S_ARMED, S_WARN: begin
                    if (kick) begin
                        w_nxt_state     = S_ARMED;
                        w_nxt_remaining = r_load;
                    end else if (arm) begin
                        w_nxt_load = timeout_value;
                        if (timeout_value == '0) begin
                            w_nxt_state     = S_EXPIRED;
                            w_nxt_remaining = '0;
                        end else begin
                            w_nxt_state     = S_ARMED;
                            w_nxt_remaining = timeout_value;
                        end
                    end else begin
                        // Expiry and warning are judged on the post-decrement value.
                        w_nxt_remaining = w_dec;
                        if (w_dec == '0)
                            w_nxt_state = S_EXPIRED;
                        else if ((WARN_CYCLES != 0) && (w_dec <= WARN_TH))
                            w_nxt_state = S_WARN;
                        else
                            w_nxt_state = S_ARMED;
                    end
                end
                S_EXPIRED: begin
                    w_nxt_remaining = '0;
                    if (ack)
                        w_nxt_state = S_IDLE;
                end
                default: begin
                    w_nxt_state     = S_IDLE;
                    w_nxt_remaining = '0;
                end
            endcase
        end
    end

    assign w_enter_expired = (w_nxt_state == S_EXPIRED) && (r_state != S_EXPIRED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_remaining    <= '0;
            r_load         <= '0;
            r_pulse        <= 1'b0;
            r_expire_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state     <= w_nxt_state;
            r_remaining <= w_nxt_remaining;
            r_load      <= w_nxt_load;
            r_pulse     <= w_enter_expired;
            if (w_enter_expired && (r_expire_count != '1))
                r_expire_count <= r_expire_count + EV_W'(1);
        end
    end

    assign state         = r_state;
    assign remaining     = r_remaining;
    assign warning       = (r_state == S_WARN);
    assign timeout       = (r_state == S_EXPIRED);
    assign timeout_pulse = r_pulse;
    assign expire_count  = r_expire_count;

endmodule

// File: tb/tb_truss_heartbeat_watchdog.sv
// Directed bench for truss_heartbeat_watchdog: a vector table for single-edge
// behaviour plus hand-written multi-cycle sequences for expiry, kicks and reset.
module tb_truss_heartbeat_watchdog;

    logic        clk;
    logic        reset_n;
    logic        arm, kick, disarm, ack;
    logic [15:0] timeout_value;
    logic [1:0]  state;
    logic [15:0] remaining;
    logic        warning, timeout, timeout_pulse;
    logic [7:0]  expire_count;

    logic        arm2, kick2, disarm2, ack2;
    logic [15:0] timeout_value2;
    logic [1:0]  state2;
    logic [15:0] remaining2;
    logic        warning2, timeout2, timeout_pulse2;
    logic [1:0]  expire_count2;

    int n_checks = 0;
    int n_pass   = 0;

    truss_heartbeat_watchdog #(.CNT_W(16), .WARN_CYCLES(8), .EV_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .kick(kick), .disarm(disarm), .ack(ack),
        .timeout_value(timeout_value), .state(state), .remaining(remaining),
        .warning(warning), .timeout(timeout), .timeout_pulse(timeout_pulse),
        .expire_count(expire_count)
    );

    truss_heartbeat_watchdog #(.CNT_W(16), .WARN_CYCLES(0), .EV_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .arm(arm2), .kick(kick2), .disarm(disarm2), .ack(ack2),
        .timeout_value(timeout_value2), .state(state2), .remaining(remaining2),
        .warning(warning2), .timeout(timeout2), .timeout_pulse(timeout_pulse2),
        .expire_count(expire_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a, k, d, ac;
        logic [15:0] tv;
        logic [1:0]  st;
        logic [15:0] rem;
        logic        warn, to, pulse;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_main(input string name, input logic [1:0] st, input logic [15:0] rem,
                              input logic w, input logic to, input logic p, input logic [7:0] c);
        check({name, " state"}, 32'(state), 32'(st));
        check({name, " remaining"}, 32'(remaining), 32'(rem));
        check({name, " warning"}, 32'(warning), 32'(w));
        check({name, " timeout"}, 32'(timeout), 32'(to));
        check({name, " pulse"}, 32'(timeout_pulse), 32'(p));
        check({name, " count"}, 32'(expire_count), 32'(c));
    endtask

    task automatic drive(input logic a, input logic k, input logic d, input logic ac,
                         input logic [15:0] tv);
        @(negedge clk);
        arm = a; kick = k; disarm = d; ack = ac; timeout_value = tv;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic a, input logic ac, input logic [15:0] tv);
        @(negedge clk);
        arm2 = a; kick2 = 1'b0; disarm2 = 1'b0; ack2 = ac; timeout_value2 = tv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        arm = 0; kick = 0; disarm = 0; ack = 0; timeout_value = '0;
        arm2 = 0; kick2 = 0; disarm2 = 0; ack2 = 0; timeout_value2 = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int   min_rem;
        int   bad_cycles;
        logic [1:0] est;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd10, 2'd1, 16'd10, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  2'd1, 16'd9,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  2'd2, 16'd8,  1'b1, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  2'd1, 16'd10, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  2'd1, 16'd9,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0,  2'd0, 16'd0,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  2'd0, 16'd0,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  2'd0, 16'd0,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd3,  2'd1, 16'd3,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  2'd2, 16'd2,  1'b1, 1'b0, 1'b0, 8'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd20, 2'd1, 16'd20, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  2'd0, 16'd0,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  2'd3, 16'd0,  1'b0, 1'b1, 1'b1, 8'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  2'd3, 16'd0,  1'b0, 1'b1, 1'b0, 8'd1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  2'd3, 16'd0,  1'b0, 1'b1, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd5,  2'd3, 16'd0,  1'b0, 1'b1, 1'b0, 8'd1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0,  2'd0, 16'd0,  1'b0, 1'b0, 1'b0, 8'd1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd9,  2'd1, 16'd9,  1'b0, 1'b0, 1'b0, 8'd1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  2'd2, 16'd8,  1'b1, 1'b0, 1'b0, 8'd1};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd30, 2'd1, 16'd9,  1'b0, 1'b0, 1'b0, 8'd1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0,  2'd0, 16'd0,  1'b0, 1'b0, 1'b0, 8'd1};

        reset_n = 1'b1;
        do_reset();
        #1;
        check_main("reset", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("reset dut2 state", 32'(state2), 32'd0);
        check("reset dut2 count", 32'(expire_count2), 32'd0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].a, vecs[i].k, vecs[i].d, vecs[i].ac, vecs[i].tv);
            check_main($sformatf("vec%0d", i), vecs[i].st, vecs[i].rem, vecs[i].warn,
                       vecs[i].to, vecs[i].pulse, vecs[i].cnt);
        end

        // Plain expiry: T=10, no kicks.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
        for (int k = 1; k <= 10; k++) begin
            idle();
            est = (k == 10) ? 2'd3 : ((10 - k) <= 8 ? 2'd2 : 2'd1);
            check_main($sformatf("expiry k%0d", k), est, 16'(10 - k), est == 2'd2,
                       est == 2'd3, k == 10, (k == 10) ? 8'd1 : 8'd0);
        end
        idle();
        check_main("expiry hold", 2'd3, 16'd0, 1'b0, 1'b1, 1'b0, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        check_main("ack", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        check_main("second expiry", 2'd3, 16'd0, 1'b0, 1'b1, 1'b1, 8'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        check_main("disarm expired", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd2);

        // Periodic kicks every 5 cycles for 100 cycles.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
        min_rem    = 10;
        bad_cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            drive(1'b0, (i % 5) == 0, 1'b0, 1'b0, 16'd0);
            if (int'(remaining) < min_rem) min_rem = int'(remaining);
            if (timeout || timeout_pulse || state == 2'd3) bad_cycles++;
        end
        check("kick min remaining", 32'(min_rem), 32'd6);
        check("kick no expiry cycles", 32'(bad_cycles), 32'd0);
        check("kick count unchanged", 32'(expire_count), 32'd2);

        // Kick on the edge that would otherwise expire.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
        for (int i = 0; i < 9; i++) idle();
        check_main("last cycle", 2'd2, 16'd1, 1'b1, 1'b0, 1'b0, 8'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        check_main("last kick", 2'd1, 16'd10, 1'b0, 1'b0, 1'b0, 8'd2);
        idle();
        check_main("after last kick", 2'd1, 16'd9, 1'b0, 1'b0, 1'b0, 8'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

        // WARN_CYCLES=0 instance: no WARN, expiry 4 edges after arm.
        drive2(1'b1, 1'b0, 16'd4);
        check("w0 arm state", 32'(state2), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            drive2(1'b0, 1'b0, 16'd0);
            check($sformatf("w0 k%0d remaining", k), 32'(remaining2), 32'(4 - k));
            check($sformatf("w0 k%0d warning", k), 32'(warning2), 32'd0);
            check($sformatf("w0 k%0d state", k), 32'(state2), (k == 4) ? 32'd3 : 32'd1);
            check($sformatf("w0 k%0d pulse", k), 32'(timeout_pulse2), (k == 4) ? 32'd1 : 32'd0);
        end
        check("w0 count 1", 32'(expire_count2), 32'd1);

        // EV_W=2 saturation over five expiries.
        for (int n = 2; n <= 5; n++) begin
            drive2(1'b0, 1'b1, 16'd0);
            check($sformatf("sat%0d ack timeout", n), 32'(timeout2), 32'd0);
            drive2(1'b1, 1'b0, 16'd0);
            check($sformatf("sat%0d pulse", n), 32'(timeout_pulse2), 32'd1);
            check($sformatf("sat%0d count", n), 32'(expire_count2), (n > 3) ? 32'd3 : 32'(n));
        end

        // Asynchronous reset in the middle of WARN.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
        idle(); idle(); idle();
        check("pre-reset warning", 32'(warning), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_main("async reset", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("async reset dut2 count", 32'(expire_count2), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
        check_main("post-reset arm", 2'd1, 16'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        idle();
        idle();
        check_main("post-reset k2", 2'd2, 16'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        idle();
        check_main("post-reset k3", 2'd3, 16'd0, 1'b0, 1'b1, 1'b1, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
